// File: rtl/nios2_camera_sccb_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nios2_camera_sccb_master_pkg - register map, STATUS bits, FSM states |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package nios2_camera_sccb_master_pkg;

  localparam logic [1:0] ADDR_DEV    = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RDATA  = 2'd3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_NACK = 1;
  localparam int STAT_DONE = 2;

  localparam int DEV_IRQ_EN_BIT = 8;
  localparam int CMD_READ_BIT   = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    TX_BYTE = 3'd2,
    TX_ACK  = 3'd3,
    RX_BYTE = 3'd4,
    RX_NA   = 3'd5,
    STOP    = 3'd6,
    GAP     = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/nios2_camera_sccb_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nios2_camera_sccb_master_if - Avalon-MM slave port bundle plus irq   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface nios2_camera_sccb_master_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

endinterface
`default_nettype wire

// File: rtl/nios2_camera_sccb_master_quarter_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sccb_quarter_tick - one-cycle tick every CLK_DIV clocks while enabled|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sccb_quarter_tick #(
  parameter int CLK_DIV = 250
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic en,
  output logic      tick
);

  localparam int             CNT_W   = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_MAX);

  // Counter is forced to zero whenever disabled so the first quarter after
  // enable is always a full CLK_DIV clocks long.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nios2_camera_sccb_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nios2_camera_sccb_master - Avalon-MM SCCB (camera I2C) master        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nios2_camera_sccb_master
  import nios2_camera_sccb_master_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  wire logic                        clk,
  input  wire logic                        reset_n,
  nios2_camera_sccb_master_if.slave        avs,
  output logic                             sio_c,
  inout  wire                              sio_d
);

  state_t      state_q, state_d;
  logic [6:0]  dev_id_q, dev_id_d;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  cmd_sub_q, cmd_sub_d;
  logic [7:0]  cmd_wr_q, cmd_wr_d;
  logic        cmd_rd_q, cmd_rd_d;
  logic        busy_q, busy_d;
  logic        nack_q, nack_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [31:0] readdata_q, readdata_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic        half_q, half_d;
  logic [7:0]  sh_q, sh_d;
  logic [1:0]  sync_q, sync_d;

  logic        wr_en;
  logic        tick;
  logic        bit_end;
  logic        sample;
  logic        sda_in;
  logic        scl;
  logic        sda_low;
  logic        last_tx_byte;
  logic        unused_wd;

  assign wr_en    = avs.chipselect & ~avs.write_n;
  assign bit_end  = tick && (qtr_q == 2'd3);
  assign sample   = tick && (qtr_q == 2'd2);
  assign sda_in   = sync_q[1];
  assign unused_wd = ^avs.writedata[31:17];

  // A write phase ends after the sub-address for reads, after the data byte for writes.
  assign last_tx_byte = cmd_rd_q ? (byte_q == 2'd1) : (byte_q == 2'd2);

  sccb_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state_q != IDLE),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    dev_id_d  = dev_id_q;
    irq_en_d  = irq_en_q;
    cmd_sub_d = cmd_sub_q;
    cmd_wr_d  = cmd_wr_q;
    cmd_rd_d  = cmd_rd_q;
    busy_d    = busy_q;
    nack_d    = nack_q;
    done_d    = done_q;
    rdata_d   = rdata_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    half_d    = half_q;
    sh_d      = sh_q;
    sync_d    = {sync_q[0], sio_d};

    if (wr_en) begin
      case (avs.address)
        ADDR_DEV: begin
          if (!busy_q) begin
            dev_id_d = avs.writedata[7:1];
            irq_en_d = avs.writedata[DEV_IRQ_EN_BIT];
          end
        end
        ADDR_CMD: begin
          if (!busy_q) begin
            cmd_wr_d  = avs.writedata[7:0];
            cmd_sub_d = avs.writedata[15:8];
            cmd_rd_d  = avs.writedata[CMD_READ_BIT];
            nack_d    = 1'b0;
            done_d    = 1'b0;
            busy_d    = 1'b1;
            half_d    = 1'b0;
            state_d   = START;
          end
        end
        ADDR_STATUS: done_d = 1'b0;
        default: ;
      endcase
    end

    if (state_q == IDLE) begin
      qtr_d = 2'd0;
    end else if (tick) begin
      qtr_d = qtr_q + 2'd1;
    end

    case (state_q)
      START: begin
        if (bit_end) begin
          state_d = TX_BYTE;
          sh_d    = {dev_id_q, half_q};
          bit_d   = 3'd0;
          byte_d  = 2'd0;
        end
      end
      TX_BYTE: begin
        if (bit_end) begin
          sh_d  = {sh_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = TX_ACK;
          end
        end
      end
      TX_ACK: begin
        if (sample && sda_in) begin
          nack_d = 1'b1;
        end
        if (bit_end) begin
          byte_d = byte_q + 2'd1;
          bit_d  = 3'd0;
          if (half_q) begin
            state_d = RX_BYTE;
          end else if (last_tx_byte) begin
            state_d = STOP;
          end else begin
            state_d = TX_BYTE;
            sh_d    = (byte_q == 2'd0) ? cmd_sub_q : cmd_wr_q;
          end
        end
      end
      RX_BYTE: begin
        if (sample) begin
          sh_d = {sh_q[6:0], sda_in};
        end
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = RX_NA;
          end
        end
      end
      RX_NA: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (cmd_rd_q && !half_q) begin
            state_d = GAP;
            half_d  = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            half_d  = 1'b0;
            if (cmd_rd_q) begin
              rdata_d = sh_q;
            end
          end
        end
      end
      GAP: begin
        if (bit_end) begin
          state_d = START;
        end
      end
      default: ;
    endcase
  end

  // Line levels are decoded from registered state only; scl is low in
  // quarters 0-1 of every data bit, so qtr_q[1] is the clock level.
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    case (state_q)
      START:   sda_low = qtr_q[1];
      TX_BYTE: begin
        scl     = qtr_q[1];
        sda_low = ~sh_q[7];
      end
      TX_ACK, RX_BYTE, RX_NA: scl = qtr_q[1];
      STOP: begin
        scl     = qtr_q[1];
        sda_low = (qtr_q != 2'd3);
      end
      default: ;
    endcase
  end

  assign sio_c = scl;
  assign sio_d = sda_low ? 1'b0 : 1'bz;

  always_comb begin
    readdata_d = '0;
    case (avs.address)
      ADDR_DEV: begin
        readdata_d[7:1]            = dev_id_q;
        readdata_d[DEV_IRQ_EN_BIT] = irq_en_q;
      end
      ADDR_CMD: begin
        readdata_d[7:0]          = cmd_wr_q;
        readdata_d[15:8]         = cmd_sub_q;
        readdata_d[CMD_READ_BIT] = cmd_rd_q;
      end
      ADDR_STATUS: begin
        readdata_d[STAT_BUSY] = busy_q;
        readdata_d[STAT_NACK] = nack_q;
        readdata_d[STAT_DONE] = done_q;
      end
      default: readdata_d[7:0] = rdata_q;
    endcase
  end

  assign avs.readdata = readdata_q;
  assign avs.irq      = done_q & irq_en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dev_id_q   <= '0;
      irq_en_q   <= 1'b0;
      cmd_sub_q  <= '0;
      cmd_wr_q   <= '0;
      cmd_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      readdata_q <= '0;
      qtr_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      half_q     <= 1'b0;
      sh_q       <= '0;
      sync_q     <= 2'b11;
    end else begin
      state_q    <= state_d;
      dev_id_q   <= dev_id_d;
      irq_en_q   <= irq_en_d;
      cmd_sub_q  <= cmd_sub_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_rd_q   <= cmd_rd_d;
      busy_q     <= busy_d;
      nack_q     <= nack_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      readdata_q <= readdata_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      half_q     <= half_d;
      sh_q       <= sh_d;
      sync_q     <= sync_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios2_camera_sccb_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nios2_camera_sccb_master - directed bench with SCCB slave model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_nios2_camera_sccb_master;
  import nios2_camera_sccb_master_pkg::*;

  localparam int CLK_DIV = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sio_c;
  wire  sio_d;

  nios2_camera_sccb_master_if bus ();

  nios2_camera_sccb_master #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus.slave),
    .sio_c   (sio_c),
    .sio_d   (sio_d)
  );

  always #5 clk = ~clk;

  pullup (sio_d);
  logic slv_drv = 1'b0;
  assign sio_d = slv_drv ? 1'b0 : 1'bz;

  int passed = 0;
  int checks = 0;

  // Slave model state: acks address/write bytes, returns slv_tx on reads.
  logic       ack_en = 1'b1;
  logic [7:0] slv_tx = 8'h76;
  logic [8:0] log_q[$];
  int         starts = 0;
  int         stops  = 0;

  initial begin
    logic scl_p, sda_p, in_frame, rd, scl, sda;
    logic [8:0] shreg;
    int bitn, byten;
    scl_p = 1'b1; sda_p = 1'b1; in_frame = 1'b0; rd = 1'b0;
    shreg = '0; bitn = 0; byten = 0;
    forever begin
      @(negedge clk);
      scl = sio_c;
      sda = sio_d;
      if (!reset_n) begin
        in_frame = 1'b0;
        slv_drv  = 1'b0;
      end else if (scl && scl_p && sda_p && !sda) begin
        starts++;
        in_frame = 1'b1; bitn = 0; byten = 0; rd = 1'b0; slv_drv = 1'b0;
      end else if (scl && scl_p && !sda_p && sda) begin
        stops++;
        in_frame = 1'b0; slv_drv = 1'b0;
      end else if (in_frame && scl && !scl_p) begin
        shreg = {shreg[7:0], sda};
        bitn++;
        if (bitn == 9) begin
          log_q.push_back(shreg);
          if (byten == 0) rd = shreg[1];
          byten++;
          bitn = 0;
        end
      end else if (in_frame && !scl && scl_p) begin
        if (bitn == 8)                slv_drv = ack_en && (byten == 0 || !rd);
        else if (rd && byten == 1)    slv_drv = !slv_tx[7-bitn];
        else                          slv_drv = 1'b0;
      end
      scl_p = scl;
      sda_p = sda;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    @(negedge clk);
    d = bus.readdata;
  endtask

  task automatic wait_done(output int busy_cycles, output logic timeout);
    bus.address = ADDR_STATUS;
    busy_cycles = 0;
    timeout = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.readdata[STAT_BUSY]) busy_cycles++;
      else if (busy_cycles > 0) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic clear_log();
    log_q.delete();
    starts = 0;
    stops  = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          bc;
    logic        to;

    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_readdata", bus.readdata, 32'h0);
    chk("rst_sio_c", {31'd0, sio_c}, 32'h1);
    chk("rst_sio_d", {31'd0, sio_d}, 32'h1);
    chk("rst_irq", {31'd0, bus.irq}, 32'h0);
    reset_n = 1'b1;
    bus_read(ADDR_DEV, rd);    chk("rst_dev", rd, 32'h0);
    bus_read(ADDR_CMD, rd);    chk("rst_cmd", rd, 32'h0);
    bus_read(ADDR_STATUS, rd); chk("rst_status", rd, 32'h0);
    bus_read(ADDR_RDATA, rd);  chk("rst_rdata", rd, 32'h0);

    // 3-phase write
    bus_write(ADDR_DEV, 32'h42);
    bus_read(ADDR_DEV, rd); chk("dev_readback", rd, 32'h42);
    clear_log();
    bus_write(ADDR_CMD, 32'h0000_1280);
    wait_done(bc, to);
    chk("wr_timeout", {31'd0, to}, 32'h0);
    chk("wr_busy_cycles", {31'd0, (bc >= 230 && bc <= 234)}, 32'h1);
    chk("wr_nbytes", 32'(log_q.size()), 32'd3);
    chk("wr_byte0", {23'd0, log_q[0]}, 32'h084);
    chk("wr_byte1", {23'd0, log_q[1]}, 32'h024);
    chk("wr_byte2", {23'd0, log_q[2]}, 32'h100);
    chk("wr_starts", 32'(starts), 32'd1);
    chk("wr_stops", 32'(stops), 32'd1);
    bus_read(ADDR_STATUS, rd); chk("wr_status", rd, 32'h4);

    // Read: 2-phase write, gap, 2-phase read
    clear_log();
    bus_write(ADDR_CMD, 32'h0001_0A00);
    wait_done(bc, to);
    chk("rd_timeout", {31'd0, to}, 32'h0);
    chk("rd_busy_cycles", {31'd0, (bc >= 326 && bc <= 330)}, 32'h1);
    chk("rd_nbytes", 32'(log_q.size()), 32'd4);
    chk("rd_byte0", {23'd0, log_q[0]}, 32'h084);
    chk("rd_byte1", {23'd0, log_q[1]}, 32'h014);
    chk("rd_byte2", {23'd0, log_q[2]}, 32'h086);
    chk("rd_data_na", {23'd0, log_q[3]}, 32'h0ED);
    chk("rd_starts", 32'(starts), 32'd2);
    chk("rd_stops", 32'(stops), 32'd2);
    bus_read(ADDR_RDATA, rd);  chk("rd_rdata", rd, 32'h76);
    bus_read(ADDR_STATUS, rd); chk("rd_status", rd, 32'h4);

    // No slave acknowledge
    ack_en = 1'b0;
    bus_write(ADDR_CMD, 32'h0000_1280);
    wait_done(bc, to);
    chk("nack_timeout", {31'd0, to}, 32'h0);
    bus_read(ADDR_STATUS, rd); chk("nack_status", rd, 32'h6);
    ack_en = 1'b1;
    bus_write(ADDR_CMD, 32'h0000_1280);
    bus_read(ADDR_STATUS, rd); chk("nack_cleared", rd, 32'h1);
    wait_done(bc, to);
    bus_read(ADDR_STATUS, rd); chk("nack_after", rd, 32'h4);

    // Writes while busy are ignored
    clear_log();
    bus_write(ADDR_CMD, 32'h0000_3355);
    repeat (10) @(negedge clk);
    bus_write(ADDR_CMD, 32'h0001_7777);
    bus_write(ADDR_DEV, 32'h1AA);
    wait_done(bc, to);
    chk("busywr_timeout", {31'd0, to}, 32'h0);
    chk("busywr_nbytes", 32'(log_q.size()), 32'd3);
    chk("busywr_byte0", {23'd0, log_q[0]}, 32'h084);
    chk("busywr_byte1", {23'd0, log_q[1]}, 32'h066);
    chk("busywr_byte2", {23'd0, log_q[2]}, 32'h0AA);
    chk("busywr_stops", 32'(stops), 32'd1);
    bus_read(ADDR_DEV, rd); chk("busywr_dev", rd, 32'h42);
    bus_read(ADDR_CMD, rd); chk("busywr_cmd", rd, 32'h3355);

    // Interrupt
    bus_write(ADDR_DEV, 32'h142);
    bus_write(ADDR_CMD, 32'h0000_1280);
    chk("irq_low_busy", {31'd0, bus.irq}, 32'h0);
    wait_done(bc, to);
    chk("irq_high_done", {31'd0, bus.irq}, 32'h1);
    bus_write(ADDR_STATUS, 32'h0);
    chk("irq_cleared", {31'd0, bus.irq}, 32'h0);
    bus_read(ADDR_STATUS, rd); chk("irq_status", rd, 32'h0);

    // Reset in the middle of the sub-address byte
    bus_write(ADDR_CMD, 32'h0000_1280);
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_sio_c", {31'd0, sio_c}, 32'h1);
    chk("midrst_sio_d", {31'd0, sio_d}, 32'h1);
    chk("midrst_irq", {31'd0, bus.irq}, 32'h0);
    chk("midrst_readdata", bus.readdata, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus_read(ADDR_STATUS, rd); chk("midrst_status", rd, 32'h0);
    bus_read(ADDR_DEV, rd);    chk("midrst_dev", rd, 32'h0);
    bus_write(ADDR_DEV, 32'h42);
    clear_log();
    bus_write(ADDR_CMD, 32'h0000_5AC3);
    wait_done(bc, to);
    chk("post_timeout", {31'd0, to}, 32'h0);
    chk("post_nbytes", 32'(log_q.size()), 32'd3);
    chk("post_byte0", {23'd0, log_q[0]}, 32'h084);
    chk("post_byte1", {23'd0, log_q[1]}, 32'h0B4);
    chk("post_byte2", {23'd0, log_q[2]}, 32'h186);
    bus_read(ADDR_STATUS, rd); chk("post_status", rd, 32'h4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
